// File: rtl/alu_32bit_pkg.sv
// Shared constants for the alu_32bit execute-stage ALU: operand width and function codes.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] FUNC_SLL  = 6'b000000;
    localparam logic [5:0] FUNC_SRL  = 6'b000010;
    localparam logic [5:0] FUNC_SRA  = 6'b000011;
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_BLTZ = 6'b111000;
    localparam logic [5:0] FUNC_BGEZ = 6'b111001;
    localparam logic [5:0] FUNC_BEQ  = 6'b111100;
    localparam logic [5:0] FUNC_BNE  = 6'b111101;
    localparam logic [5:0] FUNC_BLEZ = 6'b111110;
    localparam logic [5:0] FUNC_BGTZ = 6'b111111;

    // Branch codes pass operand A through to the result bus.
    function automatic logic func_is_branch(input logic [5:0] func);
        case (func)
            FUNC_BLTZ, FUNC_BGEZ, FUNC_BEQ,
            FUNC_BNE, FUNC_BLEZ, FUNC_BGTZ: func_is_branch = 1'b1;
            default:                        func_is_branch = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_32bit_if.sv
// Operand/result bundle for alu_32bit; Overflow_out exists only with ALU_32BIT_OVERFLOW_EN.
interface alu_32bit_if #(
    parameter int WIDTH = alu_pkg::WIDTH
);
    logic [5:0]       Func_in;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [WIDTH-1:0] O_out;
    logic             Branch_out;
`ifdef ALU_32BIT_OVERFLOW_EN
    logic             Overflow_out;
`endif

    modport master (
        output Func_in,
        output A_in,
        output B_in,
`ifdef ALU_32BIT_OVERFLOW_EN
        input  Overflow_out,
`endif
        input  O_out,
        input  Branch_out
    );

    modport slave (
        input  Func_in,
        input  A_in,
        input  B_in,
`ifdef ALU_32BIT_OVERFLOW_EN
        output Overflow_out,
`endif
        output O_out,
        output Branch_out
    );
endinterface

// File: rtl/alu_32bit_branch_cmp.sv
// Combinational branch-condition evaluator; signed tests use only the sign bit and a zero detect on A.
module alu_branch_cmp
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [5:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             taken_o
);
    logic a_neg;
    logic a_zero;
    logic a_eq_b;

    always_comb begin
        a_neg  = a_i[WIDTH-1];
        a_zero = (a_i == '0);
        a_eq_b = (a_i == b_i);
    end

    always_comb begin
        taken_o = 1'b0;
        case (func_i)
            FUNC_BLTZ: taken_o = a_neg;
            FUNC_BGEZ: taken_o = ~a_neg;
            FUNC_BEQ:  taken_o = a_eq_b;
            FUNC_BNE:  taken_o = ~a_eq_b;
            FUNC_BLEZ: taken_o = a_neg | a_zero;
            FUNC_BGTZ: taken_o = ~a_neg & ~a_zero;
            default:   taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_32bit.sv
// Registered MIPS execute-stage ALU: one-cycle result and branch flag; ALU_32BIT_OVERFLOW_EN adds Overflow_out.
module alu_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic      Clk_in,
    input  logic      Reset_in,
    alu_32bit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       func;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             sltu;

    logic [WIDTH-1:0] o_d,      o_q;
    logic             branch_d, branch_q;
    logic             taken;

    always_comb begin
        a     = bus.A_in;
        b     = bus.B_in;
        func  = bus.Func_in;
        shamt = a[SHW-1:0];
        sum   = a + b;
        diff  = a - b;
        slt   = ($signed(a) < $signed(b));
        sltu  = (a < b);
    end

    alu_branch_cmp #(
        .WIDTH(WIDTH)
    ) u_branch_cmp (
        .func_i (func),
        .a_i    (a),
        .b_i    (b),
        .taken_o(taken)
    );

    always_comb begin
        o_d      = '0;
        branch_d = taken;
        if (func_is_branch(func)) begin
            o_d = a;
        end else begin
            case (func)
                FUNC_ADD, FUNC_ADDU: o_d = sum;
                FUNC_SUB, FUNC_SUBU: o_d = diff;
                FUNC_AND:            o_d = a & b;
                FUNC_OR:             o_d = a | b;
                FUNC_XOR:            o_d = a ^ b;
                FUNC_NOR:            o_d = ~(a | b);
                FUNC_SLT:            o_d = {{(WIDTH-1){1'b0}}, slt};
                FUNC_SLTU:           o_d = {{(WIDTH-1){1'b0}}, sltu};
                FUNC_SLL:            o_d = b << shamt;
                FUNC_SRL:            o_d = b >> shamt;
                FUNC_SRA:            o_d = $signed(b) >>> shamt;
                default:             o_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            o_q      <= '0;
            branch_q <= 1'b0;
        end else begin
            o_q      <= o_d;
            branch_q <= branch_d;
        end
    end

    assign bus.O_out      = o_q;
    assign bus.Branch_out = branch_q;

`ifdef ALU_32BIT_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Signed overflow: operand signs agree (add) or differ (sub) and the result sign flips from A.
    always_comb begin
        ovf_d = 1'b0;
        case (func)
            FUNC_ADD: ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            FUNC_SUB: ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default:  ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Overflow_out = ovf_q;
`endif
endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed plan steps plus random ops against an integer reference model.
module tb_alu_32bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    alu_32bit_if #(.WIDTH(32)) bus ();

    alu_32bit #(.WIDTH(32)) dut (
        .Clk_in  (clk),
        .Reset_in(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] codes [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
                               6'h38, 6'h39, 6'h3C, 6'h3D, 6'h3E, 6'h3F};
    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h24};

    // Reference computed with 64-bit signed integer arithmetic, then truncated to 32 bits.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output logic br, output logic ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint r;
        int sh = int'(a % 32);
        o = 32'h0; br = 1'b0; ov = 1'b0;
        case (f)
            6'h20, 6'h21: begin
                r = sa + sb; o = r[31:0];
                ov = (f == 6'h20) && (r > 64'sd2147483647 || r < -64'sd2147483648);
            end
            6'h22, 6'h23: begin
                r = sa - sb; o = r[31:0];
                ov = (f == 6'h22) && (r > 64'sd2147483647 || r < -64'sd2147483648);
            end
            6'h24: o = a & b;
            6'h25: o = a | b;
            6'h26: o = a ^ b;
            6'h27: o = ~(a | b);
            6'h2A: o = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: o = (ua < ub) ? 32'd1 : 32'd0;
            6'h00: begin r = ub * (64'sd1 << sh); o = r[31:0]; end
            6'h02: begin r = ub / (64'sd1 << sh); o = r[31:0]; end
            6'h03: begin r = sb >>> sh; o = r[31:0]; end
            6'h38: begin o = a; br = (sa < 0);  end
            6'h39: begin o = a; br = (sa >= 0); end
            6'h3C: begin o = a; br = (a == b);  end
            6'h3D: begin o = a; br = (a != b);  end
            6'h3E: begin o = a; br = (sa <= 0); end
            6'h3F: begin o = a; br = (sa > 0);  end
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Func_in = f; bus.A_in = a; bus.B_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic op_model(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eo; logic eb; logic eov;
        drive(f, a, b);
        model(f, a, b, eo, eb, eov);
        check({tag, "_o"}, bus.O_out, eo);
        check({tag, "_br"}, {31'h0, bus.Branch_out}, {31'h0, eb});
`ifdef ALU_32BIT_OVERFLOW_EN
        check({tag, "_ov"}, {31'h0, bus.Overflow_out}, {31'h0, eov});
`endif
    endtask

    task automatic op_exp(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eo, input logic eb);
        drive(f, a, b);
        check({tag, "_o"}, bus.O_out, eo);
        check({tag, "_br"}, {31'h0, bus.Branch_out}, {31'h0, eb});
    endtask

    initial begin
        bus.Func_in = 6'h24; bus.A_in = 32'h0; bus.B_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o", bus.O_out, 32'h0);
        check("rst_br", {31'h0, bus.Branch_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load a nonzero result, then reset between edges and expect an immediate clear.
        op_exp("pre_rst", 6'h3D, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_o", bus.O_out, 32'h0);
        check("async_rst_br", {31'h0, bus.Branch_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("hold_rst_o", bus.O_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        op_exp("bltz", 6'h38, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        op_exp("bgez", 6'h39, 32'h0, 32'h0, 32'h0, 1'b1);
        op_exp("beq",  6'h3C, 32'h0, 32'h1, 32'h0, 1'b0);
        op_exp("bne",  6'h3D, 32'h0, 32'h1, 32'h0, 1'b1);
        op_exp("blez", 6'h3E, 32'h0, 32'h5, 32'h0, 1'b1);
        op_exp("bgtz", 6'h3F, 32'h0000000F, 32'h0, 32'h0000000F, 1'b1);
        op_exp("bltz_min", 6'h38, 32'h80000000, 32'h0, 32'h80000000, 1'b1);
        op_exp("blez_min", 6'h3E, 32'h80000000, 32'h0, 32'h80000000, 1'b1);
        op_exp("bgtz_min", 6'h3F, 32'h80000000, 32'h0, 32'h80000000, 1'b0);
        op_exp("bltz_zero", 6'h38, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
        op_exp("bgtz_zero", 6'h3F, 32'h0, 32'h1, 32'h0, 1'b0);

        op_exp("add_wrap", 6'h20, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        op_exp("sub_wrap", 6'h22, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0);
        op_exp("slt",  6'h2A, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        op_exp("sltu", 6'h2B, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);

        op_exp("sll",  6'h00, 32'h4, 32'h80000000, 32'h0, 1'b0);
        op_exp("srl",  6'h02, 32'h4, 32'h80000000, 32'h08000000, 1'b0);
        op_exp("sra",  6'h03, 32'h4, 32'h80000000, 32'hF8000000, 1'b0);
        op_exp("sll_hi", 6'h00, 32'h24, 32'h80000000, 32'h0, 1'b0);
        op_exp("srl_hi", 6'h02, 32'h24, 32'h80000000, 32'h08000000, 1'b0);
        op_exp("sra_hi", 6'h03, 32'h24, 32'h80000000, 32'hF8000000, 1'b0);
        op_exp("sll_hi1", 6'h00, 32'hFFFFFFE1, 32'h00000003, 32'h00000006, 1'b0);

        for (int i = 0; i < 4; i++) begin
            op_exp("alt_bne", 6'h3D, 32'h1234 + i, 32'h0F0F, 32'h1234 + i, 1'b1);
            op_exp("alt_and", 6'h24, 32'hFF00FF00, 32'h0FF00FF0 + i, 32'h0F000F00, 1'b0);
        end
        op_exp("unlisted", 6'h3A, 32'h12345678, 32'h12345678, 32'h0, 1'b0);

`ifdef ALU_32BIT_OVERFLOW_EN
        drive(6'h20, 32'h7FFFFFFF, 32'h1);
        check("ovf_add_o", bus.O_out, 32'h80000000);
        check("ovf_add", {31'h0, bus.Overflow_out}, 32'h1);
        drive(6'h21, 32'h7FFFFFFF, 32'h1);
        check("ovf_addu", {31'h0, bus.Overflow_out}, 32'h0);
`endif

        // In-flight op followed by reset before its capture edge: result is discarded.
        @(negedge clk);
        bus.Func_in = 6'h25; bus.A_in = 32'hA5A5A5A5; bus.B_in = 32'h1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_o", bus.O_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        op_model("post_rst", 6'h25, 32'hA5A5A5A5, 32'h1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 18)];
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            op_model("rand", f, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_32bit.md
Name: alu_32bit

Overview:
- 32-bit ALU for the MIPS datapath execute stage.
- Computes arithmetic, logic, shift and compare results and evaluates branch conditions, both selected by a 6-bit function code.
- Outputs are registered: one clock of latency between operands/function and result.
- Consumed by the writeback path (O_out) and the PC-select logic (Branch_out).

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
- Clk_in  input  1  rising-edge clock
- Reset_in  input  1  asynchronous, active-high reset
- Func_in  input  6  operation select
- A_in  input  32  operand A (rs)
- B_in  input  32  operand B (rt or immediate)
- O_out  output  32  registered result
- Branch_out  output  1  registered branch-taken flag

Behaviour:
- Reset_in high: O_out=0 and Branch_out=0 immediately, independent of Clk_in; both held while asserted. First capture happens on the first rising edge after deassertion.
- Each rising edge captures f(Func_in, A_in, B_in). Latency is exactly 1 cycle, throughput 1 op/cycle, no handshake.
- Arithmetic is modulo 2^32 with no traps; carries are discarded.
- Function codes:
  - 100000 ADD and 100001 ADDU: A+B.
  - 100010 SUB and 100011 SUBU: A-B.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT: 1 if signed A<B, else 0.
  - 101011 SLTU: same compare, unsigned.
  - 000000 SLL: B<<A[4:0].
  - 000010 SRL: B>>A[4:0], logical.
  - 000011 SRA: B>>>A[4:0], arithmetic.
  - Non-branch codes force Branch_out=0.
- Branch codes (O_out=A_in for all of them; signed tests use A[31] and A==0):
  - 111000 BLTZ: Branch=(A<0).
  - 111001 BGEZ: Branch=(A>=0).
  - 111100 BEQ: Branch=(A==B).
  - 111101 BNE: Branch=(A!=B).
  - 111110 BLEZ: Branch=(A<=0).
  - 111111 BGTZ: Branch=(A>0).
  - B_in is ignored for all branch codes except BEQ and BNE.
- Any unlisted code: O_out=0, Branch_out=0.
- Boundaries:
  - A=0x80000000 is negative: BLTZ=1, BLEZ=1, BGTZ=0.
  - A=0: BGEZ=1, BLEZ=1, BLTZ=0, BGTZ=0.
  - Shift amount uses only A[4:0]; upper bits of A are ignored.
  - Function change mid-stream: each cycle's result depends only on inputs sampled at that edge.
  - Reset asserted mid-operation discards the in-flight result.

Optional Feature:
- Macro: ALU_32BIT_OVERFLOW_EN.
- When defined:
  - Adds output port Overflow_out (1 bit), registered with the same latency and reset value 0.
  - Set to 1 on signed overflow for ADD (100000) and SUB (100010) only.
  - 0 for every other code, including ADDU and SUBU.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparams for every Func code above (FUNC_ADD ... FUNC_BGTZ).
  - WIDTH default.
- Natural sub-module: alu_branch_cmp.
  - Combinational; inputs Func, A, B; output taken flag.
  - Instantiated once.
  - The top level holds the datapath mux and output registers.

Test Plan:
- Reset: assert Reset_in between clock edges -> O_out=0 and Branch_out=0 without waiting for a clock; hold for 2 cycles, then release.
- Branch set, one per edge:
  - BLTZ, A=B=0xFFFFFFFF -> Branch_out=1, O_out=0xFFFFFFFF one cycle later.
  - BGEZ, A=B=0 -> Branch_out=1, O_out=0.
  - BEQ, A=0, B=1 -> 0.
  - BNE, A=0, B=1 -> 1.
  - BLEZ, A=0 -> 1.
  - BGTZ, A=0x0000000F -> 1.
- Arithmetic:
  - ADD 0xFFFFFFFF+1 -> O_out=0.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT A=0xFFFFFFFF, B=1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts, B=0x80000000, A=4:
  - SLL -> 0.
  - SRL -> 0x08000000.
  - SRA -> 0xF8000000.
  - A=0x24 (only A[4:0]=4 used) -> same results.
- Back-to-back and unlisted codes:
  - Alternate BNE and AND every cycle -> each output matches the inputs of the previous edge, and Branch_out drops to 0 on the AND cycles.
  - Func=0x3A (unlisted) -> O_out=0, Branch_out=0.
- With ALU_32BIT_OVERFLOW_EN defined:
  - ADD 0x7FFFFFFF+1 -> Overflow_out=1, O_out=0x80000000.
  - ADDU with the same operands -> Overflow_out=0.
